// File: rtl/fpnew_result_rob.sv
// fpnew_result_rob
//   Reorder buffer that restores issue order for floating-point results
//   coming back out of order from several opgroups.
//
//   Ports
//     clk_i, rst_ni        clock, asynchronous active-low reset
//     clr_i, flush_i       synchronous clear / flush (drop all entries)
//     issue_*              slot allocation handshake; issue_id_o is the slot index
//     res_*                result write for a previously issued slot (always ready)
//     out_*                in-order result stream from the head slot
//     err_o                one-cycle pulse after a result hits a free or already-done slot
//     busy_o               at least one slot allocated
module fpnew_result_rob #(
    parameter int unsigned Width   = 32,
    parameter int unsigned Depth   = 4,
    parameter type         TagType = logic,
    localparam int unsigned IdWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               flush_i,
    // issue side
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  TagType             issue_tag_i,
    output logic [IdWidth-1:0] issue_id_o,
    // result side
    input  logic               res_valid_i,
    output logic               res_ready_o,
    input  logic [IdWidth-1:0] res_id_i,
    input  logic [Width-1:0]   res_result_i,
    input  logic [4:0]         res_status_i,
    input  logic               res_ext_bit_i,
    // in-order output
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [Width-1:0]   out_result_o,
    output logic [4:0]         out_status_o,
    output logic               out_ext_bit_o,
    output TagType             out_tag_o,
    // status
    output logic               err_o,
    output logic               busy_o
);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    typedef logic [IdWidth:0] ptr_t;

    ptr_t               head_q, tail_q;
    logic [Depth-1:0]   alloc_q, done_q;
    logic               err_q;

    logic [Width-1:0]   result_q [Depth];
    logic [4:0]         status_q [Depth];
    logic               ext_q    [Depth];
    TagType             tag_q    [Depth];

    logic [IdWidth-1:0] head_idx, tail_idx;
    logic               empty, full;
    logic               push, pop, res_ok, res_bad, wipe;

    assign head_idx = head_q[IdWidth-1:0];
    assign tail_idx = tail_q[IdWidth-1:0];
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[IdWidth] != tail_q[IdWidth]);

    assign wipe     = flush_i | clr_i;
    assign push     = issue_valid_i & ~full;
    assign pop      = out_valid_o & out_ready_i;
    // A result is only legal for a slot that is waiting for it. A slot being
    // allocated this same cycle is not yet waiting, and the popping head is done.
    assign res_ok   = res_valid_i & alloc_q[res_id_i] & ~done_q[res_id_i];
    assign res_bad  = res_valid_i & ~res_ok;

    assign issue_ready_o = ~full;
    assign issue_id_o    = tail_idx;
    assign res_ready_o   = 1'b1;

    assign out_valid_o   = alloc_q[head_idx] & done_q[head_idx];
    assign out_result_o  = result_q[head_idx];
    assign out_status_o  = status_q[head_idx];
    assign out_ext_bit_o = ext_q[head_idx];
    assign out_tag_o     = tag_q[head_idx];

    assign err_o  = err_q;
    assign busy_o = ~empty;

    // Control state: pointers and per-slot flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else if (wipe) begin
            head_q  <= '0;
            tail_q  <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= res_bad;
            // Pop, write and push touch distinct slots whenever all are legal,
            // so their order inside this block does not matter.
            if (pop) begin
                alloc_q[head_idx] <= 1'b0;
                done_q[head_idx]  <= 1'b0;
                head_q            <= head_q + ptr_t'(1);
            end
            if (res_ok) begin
                done_q[res_id_i] <= 1'b1;
            end
            if (push) begin
                alloc_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                tail_q            <= tail_q + ptr_t'(1);
            end
        end
    end

    // Payload storage needs no reset: it is only observed through set flags.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_q[tail_idx] <= issue_tag_i;
        end
        if (res_ok) begin
            result_q[res_id_i] <= res_result_i;
            status_q[res_id_i] <= res_status_i;
            ext_q[res_id_i]    <= res_ext_bit_i;
        end
    end

endmodule

// File: tb/tb_fpnew_result_rob.sv
module tb_fpnew_result_rob;

    logic        clk_i = 1'b0;
    logic        rst_ni, clr_i, flush_i;
    logic        issue_valid_i, issue_ready_o;
    logic [7:0]  issue_tag_i;
    logic [1:0]  issue_id_o;
    logic        res_valid_i, res_ready_o;
    logic [1:0]  res_id_i;
    logic [31:0] res_result_i;
    logic [4:0]  res_status_i;
    logic        res_ext_bit_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] out_result_o;
    logic [4:0]  out_status_o;
    logic        out_ext_bit_o;
    logic [7:0]  out_tag_o;
    logic        err_o, busy_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    fpnew_result_rob #(.Width(32), .Depth(4), .TagType(logic [7:0])) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_tag_i(issue_tag_i), .issue_id_o(issue_id_o),
        .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_id_i(res_id_i),
        .res_result_i(res_result_i), .res_status_i(res_status_i),
        .res_ext_bit_i(res_ext_bit_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_result_o(out_result_o), .out_status_o(out_status_o),
        .out_ext_bit_o(out_ext_bit_o), .out_tag_o(out_tag_o),
        .err_o(err_o), .busy_o(busy_o)
    );

    typedef struct {
        logic iv; logic [7:0] tag; logic rv; logic [1:0] rid; logic [31:0] rdat;
        logic [4:0] rst; logic rext; logic ordy; logic fl;
        logic e_ov; logic [31:0] e_res; logic [4:0] e_st; logic e_ext; logic [7:0] e_tag;
        logic e_err; logic e_busy; logic e_rdy; logic [1:0] e_id;
    } vec_t;

    function automatic vec_t mk(
        input logic iv, input logic [7:0] tag, input logic rv, input logic [1:0] rid,
        input logic [31:0] rdat, input logic [4:0] rst, input logic rext,
        input logic ordy, input logic fl,
        input logic e_ov, input logic [31:0] e_res, input logic [4:0] e_st,
        input logic e_ext, input logic [7:0] e_tag,
        input logic e_err, input logic e_busy, input logic e_rdy, input logic [1:0] e_id);
        vec_t v;
        v.iv = iv; v.tag = tag; v.rv = rv; v.rid = rid; v.rdat = rdat; v.rst = rst;
        v.rext = rext; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_res = e_res; v.e_st = e_st; v.e_ext = e_ext; v.e_tag = e_tag;
        v.e_err = e_err; v.e_busy = e_busy; v.e_rdy = e_rdy; v.e_id = e_id;
        return v;
    endfunction

    function automatic logic [31:0] dat(input logic [7:0] t);
        return 32'hC000_0000 | {24'h0, t};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        issue_valid_i = 0; issue_tag_i = 0; res_valid_i = 0; res_id_i = 0;
        res_result_i = 0; res_status_i = 0; res_ext_bit_i = 0;
        out_ready_i = 0; flush_i = 0; clr_i = 0;
    endtask

    task automatic issue(input logic [7:0] t);
        idle(); issue_valid_i = 1; issue_tag_i = t; tick();
    endtask

    task automatic wr(input logic [1:0] id, input logic [31:0] d, input logic [4:0] s);
        idle(); res_valid_i = 1; res_id_i = id; res_result_i = d; res_status_i = s; tick();
    endtask

    // Model state for the mixed-traffic phase.
    int         mhead, mtail, cnt;
    logic [3:0] mdone;
    logic [7:0] mtag [4];
    int         wr_q [$];

    task automatic traffic_cycle(input logic allow_iss, input logic [7:0] t, input int k);
        logic exp_ov;
        logic do_pop, do_res, do_iss;
        int   rid;
        exp_ov = (cnt > 0) && mdone[mhead];
        chk($sformatf("trf%0d_ov", k), 32'(out_valid_o), 32'(exp_ov));
        chk($sformatf("trf%0d_rdy", k), 32'(issue_ready_o), 32'(cnt < 4));
        do_pop = exp_ov;
        if (do_pop) begin
            chk($sformatf("trf%0d_tag", k), 32'(out_tag_o), 32'(mtag[mhead]));
            chk($sformatf("trf%0d_res", k), out_result_o, dat(mtag[mhead]));
        end
        do_res = (wr_q.size() > 0);
        rid = do_res ? wr_q.pop_front() : 0;
        do_iss = allow_iss && (cnt < 4);
        idle();
        out_ready_i = do_pop;
        if (do_res) begin
            res_valid_i = 1; res_id_i = 2'(rid); res_result_i = dat(mtag[rid]);
            mdone[rid] = 1'b1;
        end
        if (do_pop) begin
            mdone[mhead] = 1'b0; mhead = (mhead + 1) % 4; cnt--;
        end
        if (do_iss) begin
            issue_valid_i = 1; issue_tag_i = t;
            mtag[mtail] = t; wr_q.push_back(mtail); mtail = (mtail + 1) % 4; cnt++;
        end
        tick();
    endtask

    vec_t vecs [18];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           iv tag   rv id data          st     ext ordy fl | ov res           st     ext tag   err busy rdy id
        vecs[0]  = mk(1, 8'hA1, 0, 0, 0,            5'h00, 0, 0, 0,   0, 0,            5'h00, 0, 8'h00, 0, 1, 1, 1);
        vecs[1]  = mk(1, 8'hB2, 0, 0, 0,            5'h00, 0, 0, 0,   0, 0,            5'h00, 0, 8'h00, 0, 1, 1, 2);
        vecs[2]  = mk(0, 8'h00, 1, 0, 32'h3F800000, 5'h01, 0, 0, 0,   1, 32'h3F800000, 5'h01, 0, 8'hA1, 0, 1, 1, 2);
        vecs[3]  = mk(0, 8'h00, 1, 1, 32'h40000000, 5'h10, 1, 1, 0,   1, 32'h40000000, 5'h10, 1, 8'hB2, 0, 1, 1, 2);
        vecs[4]  = mk(0, 8'h00, 0, 0, 0,            5'h00, 0, 1, 0,   0, 0,            5'h00, 0, 8'h00, 0, 0, 1, 2);
        vecs[5]  = mk(0, 8'h00, 0, 0, 0,            5'h00, 0, 0, 1,   0, 0,            5'h00, 0, 8'h00, 0, 0, 1, 0);
        vecs[6]  = mk(1, 8'h10, 0, 0, 0,            5'h00, 0, 0, 0,   0, 0,            5'h00, 0, 8'h00, 0, 1, 1, 1);
        vecs[7]  = mk(1, 8'h11, 0, 0, 0,            5'h00, 0, 0, 0,   0, 0,            5'h00, 0, 8'h00, 0, 1, 1, 2);
        vecs[8]  = mk(1, 8'h12, 0, 0, 0,            5'h00, 0, 0, 0,   0, 0,            5'h00, 0, 8'h00, 0, 1, 1, 3);
        vecs[9]  = mk(1, 8'h13, 0, 0, 0,            5'h00, 0, 0, 0,   0, 0,            5'h00, 0, 8'h00, 0, 1, 0, 0);
        vecs[10] = mk(1, 8'h99, 1, 3, 32'h00000D03, 5'h13, 0, 0, 0,   0, 0,            5'h00, 0, 8'h00, 0, 1, 0, 0);
        vecs[11] = mk(0, 8'h00, 1, 2, 32'h00000D02, 5'h12, 0, 0, 0,   0, 0,            5'h00, 0, 8'h00, 0, 1, 0, 0);
        vecs[12] = mk(0, 8'h00, 1, 1, 32'h00000D01, 5'h11, 0, 0, 0,   0, 0,            5'h00, 0, 8'h00, 0, 1, 0, 0);
        vecs[13] = mk(0, 8'h00, 1, 0, 32'h00000D00, 5'h10, 1, 0, 0,   1, 32'h00000D00, 5'h10, 1, 8'h10, 0, 1, 0, 0);
        vecs[14] = mk(0, 8'h00, 0, 0, 0,            5'h00, 0, 1, 0,   1, 32'h00000D01, 5'h11, 0, 8'h11, 0, 1, 1, 0);
        vecs[15] = mk(0, 8'h00, 0, 0, 0,            5'h00, 0, 1, 0,   1, 32'h00000D02, 5'h12, 0, 8'h12, 0, 1, 1, 0);
        vecs[16] = mk(0, 8'h00, 0, 0, 0,            5'h00, 0, 1, 0,   1, 32'h00000D03, 5'h13, 0, 8'h13, 0, 1, 1, 0);
        vecs[17] = mk(0, 8'h00, 0, 0, 0,            5'h00, 0, 1, 0,   0, 0,            5'h00, 0, 8'h00, 0, 0, 1, 0);

        rst_ni = 0;
        idle();
        #1;
        chk("rst_ov", 32'(out_valid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_rdy", 32'(issue_ready_o), 1);
        chk("rst_id", 32'(issue_id_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_res_rdy", 32'(res_ready_o), 1);
        tick(); tick();
        rst_ni = 1;
        tick();

        // In-order, out-of-order, full and refused-issue vectors.
        for (int i = 0; i < 18; i++) begin
            idle();
            issue_valid_i = vecs[i].iv; issue_tag_i = vecs[i].tag;
            res_valid_i = vecs[i].rv; res_id_i = vecs[i].rid; res_result_i = vecs[i].rdat;
            res_status_i = vecs[i].rst; res_ext_bit_i = vecs[i].rext;
            out_ready_i = vecs[i].ordy; flush_i = vecs[i].fl;
            tick();
            chk($sformatf("v%0d_ov", i), 32'(out_valid_o), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d_rdy", i), 32'(issue_ready_o), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_id", i), 32'(issue_id_o), 32'(vecs[i].e_id));
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d_res", i), out_result_o, vecs[i].e_res);
                chk($sformatf("v%0d_st", i), 32'(out_status_o), 32'(vecs[i].e_st));
                chk($sformatf("v%0d_ext", i), 32'(out_ext_bit_o), 32'(vecs[i].e_ext));
                chk($sformatf("v%0d_tag", i), 32'(out_tag_o), 32'(vecs[i].e_tag));
            end
        end

        // Illegal writes: unallocated slot, then duplicate write to a done slot.
        wr(2, 32'hDEAD_BEEF, 5'h1F);
        chk("ill_err", 32'(err_o), 1);
        chk("ill_busy", 32'(busy_o), 0);
        idle(); tick();
        chk("ill_err_clr", 32'(err_o), 0);
        chk("ill_ov", 32'(out_valid_o), 0);
        issue(8'h77);
        wr(0, 32'h0000_1111, 5'h01);
        chk("dup_first_ov", 32'(out_valid_o), 1);
        wr(0, 32'h0000_2222, 5'h02);
        chk("dup_err", 32'(err_o), 1);
        chk("dup_keep_res", out_result_o, 32'h0000_1111);
        chk("dup_keep_st", 32'(out_status_o), 32'h01);
        idle(); tick();
        chk("dup_err_clr", 32'(err_o), 0);
        chk("dup_tag", 32'(out_tag_o), 32'h77);
        idle(); out_ready_i = 1; tick();
        chk("dup_pop_busy", 32'(busy_o), 0);

        // Full, wrap, then mixed issue/result/pop traffic.
        idle(); flush_i = 1; tick();
        for (int i = 0; i < 4; i++) issue(8'h50 + 8'(i));
        chk("full_rdy", 32'(issue_ready_o), 0);
        chk("full_id", 32'(issue_id_o), 0);
        wr(0, dat(8'h50), 5'h00);
        chk("full_head_ov", 32'(out_valid_o), 1);
        idle(); out_ready_i = 1; tick();
        chk("wrap_rdy", 32'(issue_ready_o), 1);
        chk("wrap_id", 32'(issue_id_o), 0);
        mhead = 1; mtail = 0; cnt = 3; mdone = '0;
        for (int i = 1; i < 4; i++) begin
            mtag[i] = 8'h50 + 8'(i);
            wr_q.push_back(i);
        end
        mtag[0] = 8'h00;
        for (int k = 0; k < 12; k++) traffic_cycle(1'b1, 8'h80 + 8'(k), k);
        for (int k = 12; k < 32 && cnt > 0; k++) traffic_cycle(1'b0, 8'h00, k);
        chk("trf_drained", 32'(cnt), 0);
        chk("trf_busy", 32'(busy_o), 0);

        // Full with head done: pop wins, issue refused, ready returns next cycle.
        idle(); flush_i = 1; tick();
        for (int i = 0; i < 4; i++) issue(8'h60 + 8'(i));
        wr(0, dat(8'h60), 5'h00);
        chk("sim_ov", 32'(out_valid_o), 1);
        chk("sim_rdy0", 32'(issue_ready_o), 0);
        idle(); out_ready_i = 1; issue_valid_i = 1; issue_tag_i = 8'h99; tick();
        chk("sim_rdy1", 32'(issue_ready_o), 1);
        chk("sim_id", 32'(issue_id_o), 0);
        chk("sim_ov_next", 32'(out_valid_o), 0);
        chk("sim_busy", 32'(busy_o), 1);
        idle(); clr_i = 1; tick();
        chk("clr_busy", 32'(busy_o), 0);
        chk("clr_id", 32'(issue_id_o), 0);

        // Flush with 3 pending plus a same-cycle issue and illegal result.
        issue(8'h70); issue(8'h71); issue(8'h72);
        wr(0, dat(8'h70), 5'h00);
        idle(); flush_i = 1; issue_valid_i = 1; issue_tag_i = 8'h73;
        res_valid_i = 1; res_id_i = 3; res_result_i = 32'h1234_5678;
        tick();
        chk("fl_busy", 32'(busy_o), 0);
        chk("fl_id", 32'(issue_id_o), 0);
        chk("fl_ov", 32'(out_valid_o), 0);
        chk("fl_err", 32'(err_o), 0);
        chk("fl_rdy", 32'(issue_ready_o), 1);
        idle(); tick();
        chk("fl_err_after", 32'(err_o), 0);

        // Asynchronous reset in the middle of a result write.
        issue(8'h74); issue(8'h75);
        wr(0, dat(8'h74), 5'h00);
        idle(); res_valid_i = 1; res_id_i = 1; res_result_i = dat(8'h75);
        #2 rst_ni = 0;
        #1;
        chk("arst_ov", 32'(out_valid_o), 0);
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_rdy", 32'(issue_ready_o), 1);
        chk("arst_id", 32'(issue_id_o), 0);
        chk("arst_err", 32'(err_o), 0);
        idle(); tick();
        rst_ni = 1;
        tick();
        chk("arst_post_busy", 32'(busy_o), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fpnew_result_rob.md
FPNEW_RESULT_ROB -- requirements
Module: fpnew_result_rob

Interface
REQ-001 SHALL have parameter Width, default 32, result data width in bits.
REQ-002 SHALL have parameter Depth, default 4, number of in-flight entries; power of two, at least 2.
REQ-003 SHALL have parameter TagType, default logic, user tag type carried through in order.
REQ-004 SHALL derive localparam IdWidth = max(1, clog2(Depth)).
REQ-005 clk_i  input  1  clock; all state updates on rising edge.
REQ-006 rst_ni  input  1  reset; asynchronous, active-low.
REQ-007 clr_i  input  1  synchronous clear.
REQ-008 flush_i  input  1  synchronous flush; discards all entries.
REQ-009 issue_valid_i  input  1  upstream requests a slot.
REQ-010 issue_ready_o  output  1  slot available.
REQ-011 issue_tag_i  input  TagType  tag stored for the issued operation.
REQ-012 issue_id_o  output  IdWidth  slot index allocated on issue handshake.
REQ-013 res_valid_i  input  1  opgroup result valid.
REQ-014 res_ready_o  output  1  result accept; tied high.
REQ-015 res_id_i  input  IdWidth  slot index the result belongs to.
REQ-016 res_result_i  input  Width  result value.
REQ-017 res_status_i  input  5  status flags {NV,DZ,OF,UF,NX}.
REQ-018 res_ext_bit_i  input  1  extension bit.
REQ-019 out_valid_o  output  1  in-order result valid.
REQ-020 out_ready_i  input  1  downstream accept.
REQ-021 out_result_o / out_status_o / out_ext_bit_o / out_tag_o  output  Width/5/1/TagType  head entry contents.
REQ-022 err_o  output  1  one-cycle pulse on an illegal result write.
REQ-023 busy_o  output  1  any entry allocated.

Function
REQ-024 SHALL keep head and tail pointers of IdWidth+1 bits, wrap bit as MSB; empty when equal; full when indices are equal and wrap bits differ.
REQ-025 Each slot SHALL hold alloc and done flags plus result, status, ext_bit and tag.
REQ-026 issue_ready_o SHALL be !full, independent of same-cycle pop; issue_id_o SHALL equal tail[IdWidth-1:0] combinationally.
REQ-027 On issue_valid_i && issue_ready_o the slot at tail SHALL latch the tag, set alloc=1 and done=0, and tail SHALL increment modulo 2*Depth.
REQ-028 On res_valid_i, if slot res_id_i has alloc=1 and done=0, it SHALL latch result, status and ext_bit and set done=1.
REQ-029 On res_valid_i targeting a slot with alloc=0 or done=1, the block SHALL ignore the data, leave the slot unchanged, and pulse err_o high for exactly the next cycle.
REQ-030 out_valid_o SHALL be alloc&&done of the head slot, registered state only; a result written at edge N is visible at out_valid_o after edge N, with no combinational bypass.
REQ-031 out_* data SHALL reflect the head slot whenever out_valid_o=1; when out_valid_o=0 the data is don't-care.
REQ-032 On out_valid_o && out_ready_i the head slot SHALL clear alloc and done, and head SHALL increment.
REQ-033 Issue, result write and pop SHALL all be honoured in the same cycle.
REQ-034 A result for the head slot arriving in the cycle that slot pops is impossible (done=1) and SHALL fall under REQ-029.
REQ-035 Results SHALL be accepted in any order; output order SHALL equal issue order.
REQ-036 busy_o SHALL equal !empty.
REQ-037 flush_i or clr_i SHALL, at the next edge, clear all alloc/done flags, set head=tail=0 and drop a same-cycle issue or result; err_o SHALL not pulse.

Reset
REQ-038 While rst_ni=0: head=tail=0, all alloc/done=0, err_o=0; therefore out_valid_o=0, busy_o=0, issue_ready_o=1, issue_id_o=0.
REQ-039 Reset mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Verification
REQ-040 In-order: issue tags A,B (ids 0,1); results id0=0x3F800000 then id1=0x40000000 -> out gives A/0x3F800000 then B/0x40000000, each one cycle after its write.
REQ-041 Out-of-order: issue 4 (Depth=4), results ids 3,2,1,0 -> out_valid_o stays 0 until id0 is written, then 4 consecutive pops in tags-0..3 order with out_ready_i=1.
REQ-042 Full/wrap: 4 issues -> issue_ready_o=0; pop one -> ready=1 next cycle, next issue_id_o=0 (wrap); 10 cycles of issue+pop traffic -> no loss or reordering.
REQ-043 Illegal write: res_valid_i to unallocated id 2 -> err_o=1 for one cycle, state unchanged; duplicate write to a done slot -> err_o pulse, original data kept.
REQ-044 Simultaneous: full buffer with head done, out_ready_i=1 and issue_valid_i=1 -> pop occurs, issue refused, issue_ready_o=1 next cycle.
REQ-045 Flush/reset: 3 entries pending, flush_i=1 -> next cycle busy_o=0, issue_id_o=0; repeat with rst_ni asserted mid-result -> outputs at reset values immediately.
